// File: rtl/dm_lsu.sv
// Load/store unit between the CPU datapath and a word-ported byte memory.
// Sub-word stores go through a two-cycle read-modify-write; loads and sw take one cycle.
module dm_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              addr_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  // state | meaning
  // IDLE  | accept request; loads, sw and faults complete this cycle
  // RMW   | write merged word for a latched sb/sh
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RMW  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic [15:0]       lat_wdata;
  logic [31:0]       lat_old;

  logic              fault;
  logic              go_rmw;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       merged;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  always_comb begin
    fault = (size == 2'b11) ||
            (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
    ld_byte = 8'(dm_dout >> {addr[1:0], 3'b000});
    ld_half = 16'(dm_dout >> {addr[1], 4'b0000});
  end

  always_comb begin
    merged = lat_old;
    if (lat_size == 2'b00)
      merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata;
  end

  // Outputs are gated by rst_n so a reset during RMW kills dm_we without waiting for a clock.
  always_comb begin
    ready    = 1'b0;
    addr_err = 1'b0;
    dm_we    = 1'b0;
    rdata    = '0;
    dm_addr  = '0;
    dm_din   = '0;
    go_rmw   = 1'b0;
    if (rst_n) begin
      if (state == S_RMW) begin
        dm_addr = {lat_addr[ADDR_W-1:2], 2'b00};
        dm_din  = merged;
        dm_we   = 1'b1;
        ready   = 1'b1;
      end else begin
        dm_addr = {addr[ADDR_W-1:2], 2'b00};
        if (req) begin
          if (fault) begin
            ready    = 1'b1;
            addr_err = 1'b1;
          end else if (!wr) begin
            ready = 1'b1;
            case (size)
              2'b00:   rdata = uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
              2'b01:   rdata = uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
              default: rdata = dm_dout;
            endcase
          end else if (size == 2'b10) begin
            dm_din = wdata;
            dm_we  = 1'b1;
            ready  = 1'b1;
          end else begin
            go_rmw = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      lat_old   <= '0;
    end else begin
      state <= go_rmw ? S_RMW : S_IDLE;
      if (go_rmw) begin
        lat_addr  <= addr[ADDR_W-1:0];
        lat_size  <= size;
        lat_wdata <= wdata[15:0];
        lat_old   <= dm_dout;
      end
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a 1 KiB behavioural data memory.
module tb_dm_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, dm_din, dm_dout;
  logic        ready, addr_err, dm_we;
  logic [9:0]  dm_addr;

  logic [31:0] mem [256];
  int n_chk = 0;
  int n_fail = 0;
  int we_bad = 0;

  dm_lsu #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .addr_err(addr_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;

  // Writes must always be qualified by ready and never accompany a fault.
  always @(negedge clk) begin
    #2;
    if (rst_n && dm_we && (!ready || addr_err)) we_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completing edge.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int cyc);
    bit done = 0;
    req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
    rd = '0; er = 1'b0; cyc = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      cyc++;
      if (ready) begin
        rd = rdata; er = addr_err; done = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    req = 1'b0;
    if (!done) cyc = -1;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_cyc;
  } vec_t;

  vec_t vt [$];
  logic [31:0] rd;
  logic        er;
  int          cyc;
  time         t0;

  initial begin
    vt.push_back('{"sw10",    1, 2'b10, 0, 32'h10,     32'hDEADBEEF, 32'h0,        0, 1});
    vt.push_back('{"lw10",    0, 2'b10, 0, 32'h10,     32'h0,        32'hDEADBEEF, 0, 1});
    vt.push_back('{"sb11",    1, 2'b00, 0, 32'h11,     32'h55,       32'h0,        0, 2});
    vt.push_back('{"lw10b",   0, 2'b10, 0, 32'h10,     32'h0,        32'hDEAD55EF, 0, 1});
    vt.push_back('{"lw_hi",   0, 2'b10, 0, 32'h400410, 32'h0,        32'hDEAD55EF, 0, 1});
    vt.push_back('{"lb20",    0, 2'b00, 0, 32'h20,     32'h0,        32'h0000007F, 0, 1});
    vt.push_back('{"lb21",    0, 2'b00, 0, 32'h21,     32'h0,        32'h00000001, 0, 1});
    vt.push_back('{"lb22",    0, 2'b00, 0, 32'h22,     32'h0,        32'hFFFFFFF0, 0, 1});
    vt.push_back('{"lb23",    0, 2'b00, 0, 32'h23,     32'h0,        32'hFFFFFF80, 0, 1});
    vt.push_back('{"lbu23",   0, 2'b00, 1, 32'h23,     32'h0,        32'h00000080, 0, 1});
    vt.push_back('{"lh22",    0, 2'b01, 0, 32'h22,     32'h0,        32'hFFFF80F0, 0, 1});
    vt.push_back('{"lhu22",   0, 2'b01, 1, 32'h22,     32'h0,        32'h000080F0, 0, 1});
    vt.push_back('{"lh20",    0, 2'b01, 0, 32'h20,     32'h0,        32'h0000017F, 0, 1});
    vt.push_back('{"sh21err", 1, 2'b01, 0, 32'h21,     32'hFFFF,     32'h0,        1, 1});
    vt.push_back('{"lw20",    0, 2'b10, 0, 32'h20,     32'h0,        32'h80F0017F, 0, 1});
    vt.push_back('{"lw22err", 0, 2'b10, 0, 32'h22,     32'h0,        32'h0,        1, 1});
    vt.push_back('{"lh23err", 0, 2'b01, 0, 32'h23,     32'h0,        32'h0,        1, 1});
    vt.push_back('{"sz3ld",   0, 2'b11, 0, 32'h24,     32'h0,        32'h0,        1, 1});
    vt.push_back('{"sz3st",   1, 2'b11, 0, 32'h24,     32'h77777777, 32'h0,        1, 1});
    vt.push_back('{"sh26",    1, 2'b01, 0, 32'h26,     32'h9999BEEF, 32'h0,        0, 2});
    vt.push_back('{"lw24",    0, 2'b10, 0, 32'h24,     32'h0,        32'hBEEF0000, 0, 1});

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20 >> 2] = 32'h80F0017F;
    mem[8'h30 >> 2] = 32'h11223344;
    mem[8'h40 >> 2] = 32'hAABBCCDD;

    req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h3C; wdata = 32'hFFFFFFFF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_err",   {31'h0, addr_err}, 32'h0);
    chk("rst_we",    {31'h0, dm_we}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr",  {22'h0, dm_addr}, 32'h0);
    chk("rst_din",   dm_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);

    foreach (vt[i]) begin
      access(vt[i].w, vt[i].sz, vt[i].u, vt[i].a, vt[i].d, rd, er, cyc);
      chk({vt[i].name, "_cyc"}, 32'(cyc), 32'(vt[i].exp_cyc));
      chk({vt[i].name, "_err"}, {31'h0, er}, {31'h0, vt[i].exp_er});
      if (!vt[i].w) chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
    end
    chk("sh21_nowrite", mem[8'h20 >> 2], 32'h80F0017F);

    // Reset pulse during the RMW write cycle must suppress the write.
    req = 1'b1; wr = 1'b1; size = 2'b01; uns = 1'b0; addr = 32'h32; wdata = 32'h1234;
    #1;
    chk("rst_rmw_capture_ready", {31'h0, ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rmw_we_before", {31'h0, dm_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_we_after", {31'h0, dm_we}, 32'h0);
    chk("rst_rmw_ready_after", {31'h0, ready}, 32'h0);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rmw_mem", mem[8'h30 >> 2], 32'h11223344);
    access(0, 2'b10, 0, 32'h30, 32'h0, rd, er, cyc);
    chk("rst_rmw_idle_cyc", 32'(cyc), 32'd1);
    chk("rst_rmw_idle_rdata", rd, 32'h11223344);

    // Back-to-back sub-word stores: no bubble between RMW and the next request.
    t0 = $time;
    access(1, 2'b00, 0, 32'h40, 32'h11, rd, er, cyc);
    access(1, 2'b00, 0, 32'h41, 32'h22, rd, er, cyc);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd4);
    access(0, 2'b10, 0, 32'h40, 32'h0, rd, er, cyc);
    chk("b2b_merge", rd, 32'hAABB2211);

    chk("we_qualified", 32'(we_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
